// File: rtl/pulse_sync_pkg.sv
// Shared types and helpers for the multi-channel pulse synchronizer.
// Counter sizing and parameter legality live here.
package pulse_sync_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'd0,
    MODE_RISE   = 2'd1,
    MODE_FALL   = 2'd2
  } mode_e;

  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic bit params_ok(
    input int sync_stages,
    input int depth,
    input int mode,
    input int min_gap
  );
    return (sync_stages >= 2) && (depth >= 1) &&
           (mode >= 0) && (mode <= 2) &&
           (min_gap >= 0);
  endfunction

endpackage

// File: rtl/pulse_sync_if.sv
// Per-channel event bundle between a foreign-domain source
// and the pulse synchronizer.
interface pulse_sync_if #(
  parameter int NUM_CH = 4
) ();

  logic [NUM_CH-1:0] async_in;
  logic [NUM_CH-1:0] ovf_clr;
  logic [NUM_CH-1:0] pulse_out;
  logic [NUM_CH-1:0] ovf;
  logic [NUM_CH-1:0] busy;

  modport master (
    output async_in,
    output ovf_clr,
    input  pulse_out,
    input  ovf,
    input  busy
  );

  modport slave (
    input  async_in,
    input  ovf_clr,
    output pulse_out,
    output ovf,
    output busy
  );

endinterface

// File: rtl/pulse_sync_chan.sv
// One channel: sync chain, edge decode, pending queue,
// gap timer and sticky overflow.
module pulse_sync_chan
  import pulse_sync_pkg::*;
#(
  parameter int    SYNC_STAGES = 2,
  parameter mode_e MODE        = MODE_TOGGLE,
  parameter int    DEPTH       = 4,
  parameter int    MIN_GAP     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_armed,
  input  logic i_async,
  input  logic i_ovf_clr,
  output logic o_pulse,
  output logic o_ovf,
  output logic o_busy
);

  localparam int PW = cnt_w(DEPTH);
  localparam int GW = cnt_w(MIN_GAP);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ref;
  logic [PW-1:0]          r_pend;
  logic [GW-1:0]          r_gap;
  logic                   r_pulse;
  logic                   r_ovf;
  logic                   r_busy;

  logic          w_sync;
  logic          w_edge;
  logic          w_event;
  logic          w_full;
  logic          w_issue;
  logic          w_drop;
  logic [PW-1:0] w_pend_nx;
  logic [GW-1:0] w_gap_nx;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_edge = 1'b0;
    unique case (MODE)
      MODE_TOGGLE: w_edge = w_sync ^ r_ref;
      MODE_RISE:   w_edge = w_sync & ~r_ref;
      MODE_FALL:   w_edge = ~w_sync & r_ref;
      default:     w_edge = 1'b0;
    endcase
  end

  assign w_event = i_armed & w_edge;
  assign w_full  = (r_pend == PW'(DEPTH));
  assign w_issue = ((r_pend != '0) | w_event)
                 & (r_gap == '0);
  assign w_drop  = w_event & ~w_issue & w_full;

  // An event that coincides with an issue bypasses the queue.
  always_comb begin
    w_pend_nx = r_pend;
    if (w_event & ~w_issue & ~w_full)
      w_pend_nx = r_pend + PW'(1);
    else if (w_issue & ~w_event)
      w_pend_nx = r_pend - PW'(1);
  end

  always_comb begin
    w_gap_nx = r_gap;
    if (w_issue)
      w_gap_nx = GW'(MIN_GAP);
    else if (r_gap != '0)
      w_gap_nx = r_gap - GW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_ref   <= 1'b0;
      r_pend  <= '0;
      r_gap   <= '0;
      r_pulse <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_ref   <= w_sync;
      r_pend  <= w_pend_nx;
      r_gap   <= w_gap_nx;
      r_pulse <= w_issue;
      r_ovf   <= w_drop | (r_ovf & ~i_ovf_clr);
      r_busy  <= (w_pend_nx != '0) | w_issue
               | (w_gap_nx != '0);
    end
  end

  assign o_pulse = r_pulse;
  assign o_ovf   = r_ovf;
  assign o_busy  = r_busy;

endmodule

// File: rtl/pulse_sync_multi.sv
// Multi-channel pulse synchronizer: shared arm counter
// plus one independent pulse_sync_chan per channel.
module pulse_sync_multi
  import pulse_sync_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int DEPTH       = 4,
  parameter int MIN_GAP     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  pulse_sync_if.slave  bus
);

  localparam int    ARM_N   = SYNC_STAGES + 1;
  localparam int    AW      = cnt_w(ARM_N);
  localparam mode_e CH_MODE = mode_e'(MODE);

  if (!params_ok(SYNC_STAGES, DEPTH, MODE, MIN_GAP))
  begin : g_bad_params
    $error("pulse_sync_multi: illegal parameters");
  end

  logic [AW-1:0]     r_arm_cnt;
  logic              w_armed;
  logic [NUM_CH-1:0] w_pulse;
  logic [NUM_CH-1:0] w_ovf;
  logic [NUM_CH-1:0] w_busy;

  // Detection stays off until the ref flops hold settled data.
  assign w_armed = (r_arm_cnt == AW'(ARM_N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_arm_cnt <= '0;
    else if (!w_armed)
      r_arm_cnt <= r_arm_cnt + AW'(1);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pulse_sync_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .MODE        (CH_MODE),
      .DEPTH       (DEPTH),
      .MIN_GAP     (MIN_GAP)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_armed   (w_armed),
      .i_async   (bus.async_in[g]),
      .i_ovf_clr (bus.ovf_clr[g]),
      .o_pulse   (w_pulse[g]),
      .o_ovf     (w_ovf[g]),
      .o_busy    (w_busy[g])
    );
  end

  assign bus.pulse_out = w_pulse;
  assign bus.ovf       = w_ovf;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_pulse_sync_multi.sv
// Bench: three instances (toggle/rise/fall) against an
// event-queue reference model plus directed sequences.
module tb_pulse_sync_multi;

  localparam int NC = 4;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int G  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC-1:0] r_async = '0;
  logic [NC-1:0] r_clr = '0;

  int checks = 0;
  int errors = 0;

  pulse_sync_if #(.NUM_CH(NC)) if0 ();
  pulse_sync_if #(.NUM_CH(NC)) if1 ();
  pulse_sync_if #(.NUM_CH(NC)) if2 ();

  assign if0.async_in = r_async;
  assign if1.async_in = r_async;
  assign if2.async_in = r_async;
  assign if0.ovf_clr  = r_clr;
  assign if1.ovf_clr  = r_clr;
  assign if2.ovf_clr  = r_clr;

  pulse_sync_multi #(.NUM_CH(NC), .SYNC_STAGES(S),
    .MODE(0), .DEPTH(D), .MIN_GAP(G))
  u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  pulse_sync_multi #(.NUM_CH(NC), .SYNC_STAGES(S),
    .MODE(1), .DEPTH(D), .MIN_GAP(G))
  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  pulse_sync_multi #(.NUM_CH(NC), .SYNC_STAGES(S),
    .MODE(2), .DEPTH(D), .MIN_GAP(G))
  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic [NC-1:0] d_pulse[3];
  logic [NC-1:0] d_busy[3];
  logic [NC-1:0] d_ovf[3];
  assign d_pulse[0] = if0.pulse_out;
  assign d_pulse[1] = if1.pulse_out;
  assign d_pulse[2] = if2.pulse_out;
  assign d_busy[0]  = if0.busy;
  assign d_busy[1]  = if1.busy;
  assign d_busy[2]  = if2.busy;
  assign d_ovf[0]   = if0.ovf;
  assign d_ovf[1]   = if1.ovf;
  assign d_ovf[2]   = if2.ovf;

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: sampled-input history, per-channel
  // queue length and earliest time the next pulse may issue.
  logic [NC-1:0] samp[$];
  int  t;
  int  qn[3][NC];
  int  nxt[3][NC];
  bit  mp[3][NC];
  bit  mb[3][NC];
  bit  mo[3][NC];
  bit  cur, prv, ev, iss, drop;

  always @(posedge clk) begin
    if (!rst_n) begin
      t = 0;
      samp.delete();
      for (int m = 0; m < 3; m++)
        for (int c = 0; c < NC; c++) begin
          qn[m][c] = 0; nxt[m][c] = 0;
          mp[m][c] = 0; mb[m][c] = 0; mo[m][c] = 0;
        end
    end else begin
      samp.push_back(r_async);
      for (int m = 0; m < 3; m++)
        for (int c = 0; c < NC; c++) begin
          ev = 0;
          if (t >= S + 1) begin
            cur = samp[t-S][c];
            prv = samp[t-S-1][c];
            case (m)
              0: ev = cur ^ prv;
              1: ev = cur & ~prv;
              default: ev = ~cur & prv;
            endcase
          end
          iss  = (qn[m][c] > 0 || ev) && t >= nxt[m][c];
          drop = ev && !iss && qn[m][c] == D;
          if (iss) nxt[m][c] = t + G + 1;
          if (ev && !iss && !drop) qn[m][c]++;
          else if (iss && !ev) qn[m][c]--;
          mo[m][c] = drop || (mo[m][c] && !r_clr[c]);
          mp[m][c] = iss;
          mb[m][c] = qn[m][c] > 0 || iss || (t + 1 < nxt[m][c]);
        end
      t++;
    end
  end

  logic [NC-1:0] ep, eb, eo;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int m = 0; m < 3; m++) begin
        for (int c = 0; c < NC; c++) begin
          ep[c] = mp[m][c]; eb[c] = mb[m][c]; eo[c] = mo[m][c];
        end
        chk($sformatf("model_pulse%0d", m), d_pulse[m], ep);
        chk($sformatf("model_busy%0d", m), d_busy[m], eb);
        chk($sformatf("model_ovf%0d", m), d_ovf[m], eo);
      end
    end
  end

  int pcnt[3][NC];
  logic [NC-1:0] pprev[3];
  always @(negedge clk) begin
    for (int m = 0; m < 3; m++) begin
      for (int c = 0; c < NC; c++)
        if (d_pulse[m][c] && !pprev[m][c]) pcnt[m][c]++;
      pprev[m] = d_pulse[m];
    end
  end

  task automatic clr_cnt();
    for (int m = 0; m < 3; m++)
      for (int c = 0; c < NC; c++) pcnt[m][c] = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic burst(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      #4 r_async[ch] = ~r_async[ch];
      @(negedge clk);
    end
  endtask

  int in_rise[NC];
  int in_fall[NC];

  task automatic drive_ch(input int ch);
    logic v;
    for (int i = 0; i < 1000; i++) begin
      v = 1'($urandom_range(0, 1));
      if (v && !r_async[ch]) in_rise[ch]++;
      if (!v && r_async[ch]) in_fall[ch]++;
      r_async[ch] = v;
      repeat ($urandom_range(4, 8)) @(posedge clk);
      #($urandom_range(1, 9));
    end
  endtask

  typedef struct {
    logic [NC-1:0] in;
    logic [NC-1:0] pulse;
    logic [NC-1:0] busy;
    logic [NC-1:0] ovf;
  } vec_t;

  vec_t tbl[24];

  initial begin
    // Row i: inputs set 1 unit before edge i, outputs seen after it.
    for (int i = 0; i < 24; i++)
      tbl[i] = '{in: 4'b0011, pulse: 4'b0000,
                 busy: 4'b0000, ovf: 4'b0000};
    for (int i = 2; i <= 4; i++) tbl[i].busy = 4'b0010;
    tbl[2].pulse = 4'b0010;
    tbl[6].in = 4'b0111;
    tbl[8].in = 4'b0111;
    for (int i = 8; i <= 22; i++) tbl[i].busy = 4'b0100;
    for (int i = 8; i <= 20; i += 4) tbl[i].pulse = 4'b0100;

    r_async = 4'b0001;
    r_clr = '0;
    rst_n = 1'b0;
    clr_cnt();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("arm_pulse0", if0.pulse_out[0], 1'b0);
      chk("arm_busy0", if0.busy[0], 1'b0);
    end

    for (int i = 0; i < 24; i++) begin
      #4 r_async = tbl[i].in;
      @(negedge clk);
      chk($sformatf("tbl%0d_pulse", i), if0.pulse_out, tbl[i].pulse);
      chk($sformatf("tbl%0d_busy", i), if0.busy, tbl[i].busy);
      chk($sformatf("tbl%0d_ovf", i), if0.ovf, tbl[i].ovf);
    end

    clr_cnt();
    burst(3, 8);
    cyc(30);
    chk("burst8_pulses", pcnt[0][3], 6);
    chk("burst8_ovf", if0.ovf[3], 1'b1);
    chk("burst8_idle", if0.busy[3], 1'b0);

    #4 r_clr[3] = 1'b1;
    #0 r_async[3] = ~r_async[3];
    @(negedge clk);
    burst(3, 7);
    cyc(2);
    #4 r_clr[3] = 1'b0;
    @(negedge clk);
    chk("clr_vs_drop", if0.ovf[3], 1'b1);
    cyc(30);
    #4 r_clr[3] = 1'b1;
    @(negedge clk);
    chk("clr_alone", if0.ovf[3], 1'b0);
    #4 r_clr[3] = 1'b0;
    @(negedge clk);

    burst(3, 8);
    cyc(3);
    #1 chk("pre_rst_pulse", if0.pulse_out[3], 1'b1);
    chk("pre_rst_ovf", if0.ovf[3], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pulse", if0.pulse_out, 4'b0000);
    chk("rst_busy", if0.busy, 4'b0000);
    chk("rst_ovf", if0.ovf, 4'b0000);
    cyc(2);
    #2 rst_n = 1'b1;
    clr_cnt();
    cyc(30);
    for (int m = 0; m < 3; m++)
      for (int c = 0; c < NC; c++)
        chk($sformatf("post_rst_pulses%0d_%0d", m, c),
            pcnt[m][c], 0);

    clr_cnt();
    for (int c = 0; c < NC; c++) begin
      in_rise[c] = 0;
      in_fall[c] = 0;
    end
    #3;
    fork
      drive_ch(0);
      drive_ch(1);
      drive_ch(2);
      drive_ch(3);
    join
    cyc(5);
    for (int i = 0; i < 200; i++) begin
      if ((if0.busy | if1.busy | if2.busy) == '0) break;
      @(negedge clk);
    end
    chk("drain", if0.busy | if1.busy | if2.busy, 4'b0000);
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("rise_cnt%0d", c), pcnt[1][c], in_rise[c]);
      chk($sformatf("fall_cnt%0d", c), pcnt[2][c], in_fall[c]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
